// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and defaults for the mem_responder block.
//   state_e       : controller states (CLEAR, IDLE, LOAD, DONE)
//   AW_DEF/DW_DEF : default address / data widths
//   INIT_BYTE_DEF : default fill value written by the clear sequencer (NOP)
package mem_responder_pkg;

    localparam int          AW_DEF        = 8;
    localparam int          DW_DEF        = 8;
    localparam logic [7:0]  INIT_BYTE_DEF = 8'h00;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: plain single-port synchronous RAM, 2**AW x DW.
// Read-first: rdata_o gets the old contents of addr_i on every enabled edge.
// Kept free of resets and byte enables so it maps onto block RAM.
//   clk_i   : clock
//   ce_i    : port enable; when low, neither memory nor rdata_o changes
//   we_i    : write enable (qualified by ce_i)
//   addr_i  : address
//   wdata_i : write data
//   rdata_o : registered read data
module mem_responder_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          ce_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the CPU memory bus. A 2**AW x DW RAM shared
// between the CPU port, a host byte loader and a post-reset clear sequencer.
// The CPU port only has access in IDLE; otherwise its writes are dropped and
// it reads back INIT_BYTE.
//
// Optional write protection: define MEM_RESPONDER_WRPROT_EN to add wp_limit /
// wp_fault. CPU writes below wp_limit are dropped and flag a sticky fault.
//
// Ports:
//   clk_qzt, reset          : clock, synchronous active-high reset
//   en                      : global enable; low freezes everything
//   cpu_addr/wdata/we/rdata : CPU bus, read data one cycle after address
//   ld_start/ld_base        : begin a load at ld_base (IDLE only)
//   ld_valid/ld_data/ld_last: host byte stream, ld_last marks the final byte
//   ld_ready                : byte accepted this cycle when ld_valid is high
//   ld_sum                  : mod-2**DW sum of bytes accepted in the current load
//   ld_done                 : one-cycle pulse after the final byte is written
//   busy                    : clear or load in progress
//   wp_limit, wp_fault      : (optional) protection limit, sticky fault flag
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int            AW             = AW_DEF,
    parameter int            DW             = DW_DEF,
    parameter logic [DW-1:0] INIT_BYTE      = DW'(INIT_BYTE_DEF),
    parameter bit            CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk_qzt,
    input  logic          reset,
    input  logic          en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [DW-1:0] ld_sum,
    output logic          ld_done,
    output logic          busy
`ifdef MEM_RESPONDER_WRPROT_EN
    ,
    input  logic [AW-1:0] wp_limit,
    output logic          wp_fault
`endif
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] sum_q, sum_d;
    // cpu_rdata comes either straight from the RAM (plain reads) or from a
    // local register (write-through data, INIT_BYTE while blocked, reset 0).
    logic [DW-1:0] rdata_q, rdata_d;
    logic          src_ram_q, src_ram_d;

    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          wr_ok;
`ifdef MEM_RESPONDER_WRPROT_EN
    logic          wp_fault_q, wp_fault_d;
    logic          wp_hit;
    assign wp_hit = cpu_addr < wp_limit;
`endif

    // Reset blocks the RAM outright so an aborted clear/load writes nothing.
    assign ram_ce = en && !reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        rdata_d   = rdata_q;
        src_ram_d = src_ram_q;
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        wr_ok     = 1'b0;
`ifdef MEM_RESPONDER_WRPROT_EN
        wp_fault_d = wp_fault_q;
`endif
        if (en) begin
            unique case (state_q)
                CLEAR: begin
                    ram_we    = 1'b1;
                    ram_addr  = cnt_q;
                    ram_wdata = INIT_BYTE;
                    cnt_d     = cnt_q + AW'(1);
                    rdata_d   = INIT_BYTE;
                    src_ram_d = 1'b0;
                    if (cnt_q == '1) state_d = IDLE;
                end
                IDLE: begin
`ifdef MEM_RESPONDER_WRPROT_EN
                    wr_ok = cpu_we && !wp_hit;
                    if (cpu_we && wp_hit) wp_fault_d = 1'b1;
`else
                    wr_ok = cpu_we;
`endif
                    if (wr_ok) begin
                        ram_we    = 1'b1;
                        rdata_d   = cpu_wdata;
                        src_ram_d = 1'b0;
                    end else begin
                        // Plain read, or a protected write that reads back
                        // the existing contents.
                        src_ram_d = 1'b1;
                    end
                    if (ld_start) begin
                        state_d = LOAD;
                        cnt_d   = ld_base;
                        sum_d   = '0;
                    end
                end
                LOAD: begin
                    rdata_d   = INIT_BYTE;
                    src_ram_d = 1'b0;
                    if (ld_valid) begin
                        ram_we    = 1'b1;
                        ram_addr  = cnt_q;
                        ram_wdata = ld_data;
                        cnt_d     = cnt_q + AW'(1);
                        sum_d     = sum_q + ld_data;
                        if (ld_last) state_d = DONE;
                    end
                end
                DONE: begin
                    rdata_d   = INIT_BYTE;
                    src_ram_d = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            rdata_q    <= '0;
            src_ram_q  <= 1'b0;
`ifdef MEM_RESPONDER_WRPROT_EN
            wp_fault_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            rdata_q    <= rdata_d;
            src_ram_q  <= src_ram_d;
`ifdef MEM_RESPONDER_WRPROT_EN
            wp_fault_q <= wp_fault_d;
`endif
        end
    end

    mem_responder_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk_i   (clk_qzt),
        .ce_i    (ram_ce),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign cpu_rdata = src_ram_q ? ram_rdata : rdata_q;
    assign ld_ready  = en && (state_q == LOAD);
    assign ld_sum    = sum_q;
    assign ld_done   = (state_q == DONE);
    assign busy      = (state_q == CLEAR) || (state_q == LOAD);
`ifdef MEM_RESPONDER_WRPROT_EN
    assign wp_fault  = wp_fault_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder.
// dut  : CLEAR_ON_RESET=1, checked every cycle against a transaction-level
//        model (memory array, clear countdown, load flag) plus literal checks.
// dut0 : CLEAR_ON_RESET=0, used to show that an aborted load keeps the
//        bytes already written.
module tb_mem_responder;

    localparam logic [7:0] INIT = 8'h00;

    logic       clk;
    logic       reset, en, cpu_we, ld_start, ld_valid, ld_last;
    logic [7:0] cpu_addr, cpu_wdata, ld_base, ld_data;
    logic [7:0] cpu_rdata, ld_sum;
    logic       ld_ready, ld_done, busy;

    logic       b_reset, b_en, b_cpu_we, b_ld_start, b_ld_valid, b_ld_last;
    logic [7:0] b_cpu_addr, b_cpu_wdata, b_ld_base, b_ld_data;
    logic [7:0] b_cpu_rdata, b_ld_sum;
    logic       b_ld_ready, b_ld_done, b_busy;

`ifdef MEM_RESPONDER_WRPROT_EN
    logic [7:0] wp_limit, b_wp_limit;
    logic       wp_fault, b_wp_fault;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk_qzt(clk), .reset(reset), .en(en),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_sum(ld_sum), .ld_done(ld_done),
        .busy(busy)
`ifdef MEM_RESPONDER_WRPROT_EN
        , .wp_limit(wp_limit), .wp_fault(wp_fault)
`endif
    );

    mem_responder #(.CLEAR_ON_RESET(1'b0)) dut0 (
        .clk_qzt(clk), .reset(b_reset), .en(b_en),
        .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_we(b_cpu_we), .cpu_rdata(b_cpu_rdata),
        .ld_start(b_ld_start), .ld_base(b_ld_base), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
        .ld_last(b_ld_last), .ld_ready(b_ld_ready), .ld_sum(b_ld_sum), .ld_done(b_ld_done),
        .busy(b_busy)
`ifdef MEM_RESPONDER_WRPROT_EN
        , .wp_limit(b_wp_limit), .wp_fault(b_wp_fault)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model of dut ----------------
    logic [7:0] mmem [256];
    int         clear_left = 0;   // clear writes still to come
    bit         loading    = 1'b0;
    bit         done_p     = 1'b0;
    logic [7:0] m_ptr = 8'h00, m_sum = 8'h00, m_rd = 8'h00;
    bit         m_wpf  = 1'b0;
    bit         chk_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            clear_left = 256;
            loading    = 1'b0;
            done_p     = 1'b0;
            m_sum      = 8'h00;
            m_rd       = 8'h00;
            m_wpf      = 1'b0;
            chk_on     = 1'b1;
        end else if (en) begin
            if (clear_left > 0) begin
                mmem[8'(256 - clear_left)] = INIT;
                clear_left--;
                m_rd = INIT;
            end else if (loading) begin
                m_rd = INIT;
                if (ld_valid) begin
                    mmem[m_ptr] = ld_data;
                    m_ptr = m_ptr + 8'd1;
                    m_sum = m_sum + ld_data;
                    if (ld_last) begin
                        loading = 1'b0;
                        done_p  = 1'b1;
                    end
                end
            end else if (done_p) begin
                done_p = 1'b0;
                m_rd   = INIT;
            end else begin
                if (cpu_we) begin
`ifdef MEM_RESPONDER_WRPROT_EN
                    if (cpu_addr < wp_limit) begin
                        m_wpf = 1'b1;
                        m_rd  = mmem[cpu_addr];
                    end else begin
                        mmem[cpu_addr] = cpu_wdata;
                        m_rd = cpu_wdata;
                    end
`else
                    mmem[cpu_addr] = cpu_wdata;
                    m_rd = cpu_wdata;
`endif
                end else begin
                    m_rd = mmem[cpu_addr];
                end
                if (ld_start) begin
                    loading = 1'b1;
                    m_ptr   = ld_base;
                    m_sum   = 8'h00;
                end
            end
        end
        #1;
        if (chk_on) begin
            chk("cpu_rdata", cpu_rdata, m_rd);
            chk("busy", busy, (clear_left > 0) || loading);
            chk("ld_ready", ld_ready, loading && en);
            chk("ld_done", ld_done, done_p);
            chk("ld_sum", ld_sum, m_sum);
`ifdef MEM_RESPONDER_WRPROT_EN
            chk("wp_fault", wp_fault, m_wpf);
`endif
            if (ld_done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic cpu_rd(input logic [7:0] a, output logic [7:0] d);
        cpu_addr = a; cpu_we = 1'b0;
        @(negedge clk);
        d = cpu_rdata;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, 256);
    endtask

    task automatic b_rd(input logic [7:0] a, output logic [7:0] d);
        b_cpu_addr = a; b_cpu_we = 1'b0;
        @(negedge clk);
        d = b_cpu_rdata;
    endtask

    logic [7:0] rd;
    int         d0;

    initial begin
        reset = 1'b1; en = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ld_start = 1'b0; ld_base = 8'h00; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        b_reset = 1'b1; b_en = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 8'h00; b_cpu_wdata = 8'h00;
        b_ld_start = 1'b0; b_ld_base = 8'h00; b_ld_valid = 1'b0; b_ld_data = 8'h00; b_ld_last = 1'b0;
`ifdef MEM_RESPONDER_WRPROT_EN
        wp_limit = 8'h00; b_wp_limit = 8'h00;
`endif
        repeat (2) @(negedge clk);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_sum", ld_sum, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_busy", busy, 1);
        reset = 1'b0;

        // clear sequence: busy for exactly 256 cycles, memory reads as NOP
        wait_clear();
        cpu_rd(8'h00, rd); chk("clr_rd00", rd, 8'h00);
        cpu_rd(8'h7F, rd); chk("clr_rd7f", rd, 8'h00);
        cpu_rd(8'hFF, rd); chk("clr_rdff", rd, 8'h00);

        // load wrapping past the top of memory
        ld_base = 8'hFE; ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hC3;
        @(negedge clk);
        ld_data = 8'h10;
        @(negedge clk);
        ld_data = 8'h06; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ld_done_pulse", ld_done, 1);
        chk("ld_sum_d9", ld_sum, 8'hD9);
        @(negedge clk);
        chk("ld_done_once", done_cnt, 1);
        cpu_rd(8'hFE, rd); chk("ld_fe", rd, 8'hC3);
        cpu_rd(8'hFF, rd); chk("ld_ff", rd, 8'h10);
        cpu_rd(8'h00, rd); chk("ld_00", rd, 8'h06);
        chk("ld_sum_hold", ld_sum, 8'hD9);

        // IDLE write-through then read-back
        cpu_wr(8'h10, 8'h42); chk("wr_through", cpu_rdata, 8'h42);
        cpu_rd(8'h10, rd);    chk("rd_10", rd, 8'h42);

        // en low: no write, output holds
        en = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'hEE; cpu_we = 1'b1;
        @(negedge clk);
        chk("en0_hold", cpu_rdata, 8'h42);
        en = 1'b1; cpu_we = 1'b0;
        cpu_rd(8'h10, rd); chk("en0_nowr", rd, 8'h42);

        // CPU write during LOAD is dropped
        cpu_wr(8'h20, 8'h77);
        ld_base = 8'h80; ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        cpu_addr = 8'h20; cpu_wdata = 8'h55; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
        chk("blk_rdata", cpu_rdata, 8'h00);
        ld_valid = 1'b1; ld_data = 8'h01; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        cpu_rd(8'h20, rd); chk("blk_kept", rd, 8'h77);
        cpu_rd(8'h80, rd); chk("blk_ld80", rd, 8'h01);

`ifdef MEM_RESPONDER_WRPROT_EN
        wp_limit = 8'h10;
        cpu_wr(8'h05, 8'hAA);
        chk("wp_rdata", cpu_rdata, 8'h00);
        chk("wp_fault", wp_fault, 1);
        cpu_rd(8'h05, rd); chk("wp_unchanged", rd, 8'h00);
        cpu_wr(8'h10, 8'h99);
        cpu_rd(8'h10, rd); chk("wp_limit_ok", rd, 8'h99);
        chk("wp_sticky", wp_fault, 1);
        wp_limit = 8'h00;
`endif

        // reset in the middle of a load: no ld_done, back to CLEAR
        d0 = done_cnt;
        ld_base = 8'h40; ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h11;
        @(negedge clk);
        ld_data = 8'h22;
        @(negedge clk);
        ld_data = 8'h33; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ld_valid = 1'b0;
        chk("abort_busy", busy, 1);
        chk("abort_done", ld_done, 0);
        chk("abort_sum", ld_sum, 0);
        wait_clear();
        chk("abort_no_done", done_cnt, d0);
        cpu_rd(8'h40, rd); chk("abort_cleared", rd, 8'h00);

        // same abort on the CLEAR_ON_RESET=0 instance keeps the early bytes
        b_reset = 1'b0;
        @(negedge clk);
        chk("b_idle", b_busy, 0);
        b_ld_base = 8'h30; b_ld_start = 1'b1;
        @(negedge clk);
        b_ld_start = 1'b0;
        b_ld_valid = 1'b1; b_ld_data = 8'hA1;
        @(negedge clk);
        b_ld_data = 8'hB2;
        @(negedge clk);
        chk("b_sum2", b_ld_sum, 8'h53);
        b_ld_data = 8'hC3; b_reset = 1'b1;
        @(negedge clk);
        b_reset = 1'b0; b_ld_valid = 1'b0;
        chk("b_abort_busy", b_busy, 0);
        chk("b_abort_done", b_ld_done, 0);
        b_rd(8'h30, rd); chk("b_keep30", rd, 8'hA1);
        chk("b_no_done", b_ld_done, 0);
        b_rd(8'h31, rd); chk("b_keep31", rd, 8'hB2);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
